axi_region_decerr_slave: RTL and testbench

//  Parametrised AXI4 address decoder plus default (decode-error) slave for the SoC interconnect.

---
 rtl/axi_region_decerr_slave.sv | 180 ++++++++++++++++++
 tb/tb_axi_region_decerr_slave.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_region_decerr_slave.sv
// AXI4 address decoder with runtime-programmable windows and a built-in decode-error slave.
// Misses are accepted combinationally, writes are drained to a DECERR B, reads return zero DECERR beats.
module axi_region_decerr_slave #(
  parameter int NB_REGION      = 3,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NB_REGION*AXI_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_REGION*AXI_ADDR_WIDTH-1:0] end_addr_i,
  input  logic [NB_REGION-1:0]                region_en_i,
  input  logic                                aw_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]           aw_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]             aw_id_i,
  input  logic [7:0]                          aw_len_i,
  output logic                                aw_ready_o,
  output logic [NB_REGION-1:0]                aw_sel_o,
  output logic                                aw_miss_o,
  input  logic                                w_valid_i,
  input  logic                                w_last_i,
  output logic                                w_ready_o,
  output logic                                b_valid_o,
  output logic [AXI_ID_WIDTH-1:0]             b_id_o,
  output logic [1:0]                          b_resp_o,
  input  logic                                b_ready_i,
  input  logic                                ar_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]           ar_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]             ar_id_i,
  input  logic [7:0]                          ar_len_i,
  output logic                                ar_ready_o,
  output logic [NB_REGION-1:0]                ar_sel_o,
  output logic                                ar_miss_o,
  output logic                                r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]           r_data_o,
  output logic [1:0]                          r_resp_o,
  output logic                                r_last_o,
  output logic [AXI_ID_WIDTH-1:0]             r_id_o,
  input  logic                                r_ready_i,
  input  logic                                err_clr_i,
  output logic [CNT_WIDTH-1:0]                err_cnt_o
);

  localparam int AW = AXI_ADDR_WIDTH;

  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t       w_state;
  r_state_t       r_state;
  logic [7:0]     beat_cnt;
  logic           aw_hs;
  logic           ar_hs;
  logic [1:0]     inc;
  logic [CNT_WIDTH:0] cnt_sum;
  logic           unused_len;

  // Scanning from the top index down lets the lowest-indexed hit overwrite the others.
  function automatic logic [NB_REGION-1:0] decode(
    input logic [AW-1:0]           addr,
    input logic [NB_REGION*AW-1:0] s,
    input logic [NB_REGION*AW-1:0] e,
    input logic [NB_REGION-1:0]    en
  );
    logic [NB_REGION-1:0] sel;
    sel = '0;
    for (int i = NB_REGION - 1; i >= 0; i--) begin
      if (en[i] && (addr >= s[i*AW +: AW]) && (addr <= e[i*AW +: AW])) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

  assign aw_sel_o   = decode(aw_addr_i, start_addr_i, end_addr_i, region_en_i);
  assign ar_sel_o   = decode(ar_addr_i, start_addr_i, end_addr_i, region_en_i);
  assign aw_miss_o  = ~|aw_sel_o;
  assign ar_miss_o  = ~|ar_sel_o;

  assign aw_ready_o = (w_state == W_IDLE) && aw_miss_o;
  assign ar_ready_o = (r_state == R_IDLE) && ar_miss_o;
  assign aw_hs      = aw_valid_i && aw_ready_o;
  assign ar_hs      = ar_valid_i && ar_ready_o;
  assign r_data_o   = '0;
  assign unused_len = ^aw_len_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      w_ready_o <= 1'b0;
      b_valid_o <= 1'b0;
      b_resp_o  <= 2'b00;
      b_id_o    <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            b_id_o    <= aw_id_i;
            w_ready_o <= 1'b1;
            w_state   <= W_DRAIN;
          end
        end
        W_DRAIN: begin
          if (w_valid_i && w_last_i) begin
            w_ready_o <= 1'b0;
            b_valid_o <= 1'b1;
            b_resp_o  <= 2'b11;
            w_state   <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            b_valid_o <= 1'b0;
            b_resp_o  <= 2'b00;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // r_last is registered, so it is precomputed from the count of beats still to go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      beat_cnt  <= 8'd0;
      r_valid_o <= 1'b0;
      r_last_o  <= 1'b0;
      r_resp_o  <= 2'b00;
      r_id_o    <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_id_o    <= ar_id_i;
            beat_cnt  <= ar_len_i;
            r_valid_o <= 1'b1;
            r_resp_o  <= 2'b11;
            r_last_o  <= (ar_len_i == 8'd0);
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_ready_i) begin
            if (r_last_o) begin
              r_valid_o <= 1'b0;
              r_last_o  <= 1'b0;
              r_resp_o  <= 2'b00;
              r_state   <= R_IDLE;
            end else begin
              beat_cnt <= beat_cnt - 8'd1;
              r_last_o <= (beat_cnt == 8'd1);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign inc     = {1'b0, aw_hs} + {1'b0, ar_hs};
  assign cnt_sum = {1'b0, err_cnt_o} + {{(CNT_WIDTH-1){1'b0}}, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_o <= '0;
    end else if (err_clr_i) begin
      err_cnt_o <= '0;
    end else if (cnt_sum[CNT_WIDTH]) begin
      err_cnt_o <= '1;
    end else begin
      err_cnt_o <= cnt_sum[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_axi_region_decerr_slave.sv
// Directed bench for axi_region_decerr_slave: decode, error write/read, overlap, counter saturation, reset.
module tb_axi_region_decerr_slave;
  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int CW = 8;  // narrow counter keeps the saturation scenario short

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR*AW-1:0] start_addr, end_addr;
  logic [NR-1:0]  region_en;
  logic           aw_valid;
  logic [AW-1:0]  aw_addr;
  logic [IW-1:0]  aw_id;
  logic [7:0]     aw_len;
  logic           aw_ready;
  logic [NR-1:0]  aw_sel;
  logic           aw_miss;
  logic           w_valid, w_last, w_ready;
  logic           b_valid;
  logic [IW-1:0]  b_id;
  logic [1:0]     b_resp;
  logic           b_ready;
  logic           ar_valid;
  logic [AW-1:0]  ar_addr;
  logic [IW-1:0]  ar_id;
  logic [7:0]     ar_len;
  logic           ar_ready;
  logic [NR-1:0]  ar_sel;
  logic           ar_miss;
  logic           r_valid;
  logic [DW-1:0]  r_data;
  logic [1:0]     r_resp;
  logic           r_last;
  logic [IW-1:0]  r_id;
  logic           r_ready;
  logic           err_clr;
  logic [CW-1:0]  err_cnt;

  int checks = 0;
  int failures = 0;

  axi_region_decerr_slave #(
    .NB_REGION(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .AXI_ID_WIDTH(IW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_addr_i(start_addr), .end_addr_i(end_addr), .region_en_i(region_en),
    .aw_valid_i(aw_valid), .aw_addr_i(aw_addr), .aw_id_i(aw_id), .aw_len_i(aw_len),
    .aw_ready_o(aw_ready), .aw_sel_o(aw_sel), .aw_miss_o(aw_miss),
    .w_valid_i(w_valid), .w_last_i(w_last), .w_ready_o(w_ready),
    .b_valid_o(b_valid), .b_id_o(b_id), .b_resp_o(b_resp), .b_ready_i(b_ready),
    .ar_valid_i(ar_valid), .ar_addr_i(ar_addr), .ar_id_i(ar_id), .ar_len_i(ar_len),
    .ar_ready_o(ar_ready), .ar_sel_o(ar_sel), .ar_miss_o(ar_miss),
    .r_valid_o(r_valid), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
    .r_id_o(r_id), .r_ready_i(r_ready),
    .err_clr_i(err_clr), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_map();
    start_addr = {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000};
    end_addr   = {32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF};
    region_en  = 3'b111;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_map();
    aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0;
    w_valid = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0;
    r_ready = 0; err_clr = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({w_ready, b_valid, r_valid, r_last} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_valids got=%b exp=0000", {w_ready, b_valid, r_valid, r_last});
    end
    checks++;
    if ({b_resp, r_resp, b_id, r_id} !== 12'h000) begin
      failures++;
      $display("FAIL reset_resp_id got=%h exp=000", {b_resp, r_resp, b_id, r_id});
    end
    checks++;
    if (r_data !== 32'h0 || err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_data_cnt data=%h cnt=%h exp=0/0", r_data, err_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    logic [AW-1:0] addrs [3];
    logic [NR-1:0] sels  [3];
    addrs[0] = 32'h0010_0004; sels[0] = 3'b010;
    addrs[1] = 32'h1A11_FFFF; sels[1] = 3'b100;
    addrs[2] = 32'h1A12_0000; sels[2] = 3'b000;
    for (int i = 0; i < 3; i++) begin
      ar_addr = addrs[i];
      #1;
      checks++;
      if (ar_sel !== sels[i] || ar_miss !== (i == 2) || ar_ready !== (i == 2)) begin
        failures++;
        $display("FAIL decode[%0d] sel=%b miss=%b ready=%b exp sel=%b miss=ready=%0d",
                 i, ar_sel, ar_miss, ar_ready, sels[i], (i == 2));
      end
    end
    ar_addr = 32'h0;
    tick();
  endtask

  task automatic test_write();
    int wr_cycles = 0;
    int aw_busy = 0;
    aw_valid = 1; aw_addr = 32'h3000_0000; aw_id = 4'd5; aw_len = 8'd3;
    #1;
    checks++;
    if (aw_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_aw_ready got=%b exp=1", aw_ready);
    end
    tick();
    aw_valid = 0;
    for (int k = 0; k < 4; k++) begin
      w_valid = 1; w_last = (k == 3);
      #1;
      if (w_ready === 1'b1) wr_cycles++;
      if (aw_ready !== 1'b0) aw_busy++;
      tick();
    end
    w_valid = 0; w_last = 0;
    checks++;
    if (wr_cycles !== 4 || aw_busy !== 0) begin
      failures++;
      $display("FAIL wr_drain w_ready_cycles=%0d aw_ready_during=%0d exp=4/0", wr_cycles, aw_busy);
    end
    checks++;
    if (w_ready !== 1'b0 || b_valid !== 1'b1 || b_id !== 4'd5 || b_resp !== 2'b11) begin
      failures++;
      $display("FAIL wr_b w_ready=%b b_valid=%b id=%0d resp=%b exp 0/1/5/11", w_ready, b_valid, b_id, b_resp);
    end
    tick();
    checks++;
    if (b_valid !== 1'b1) begin
      failures++;
      $display("FAIL wr_b_hold got=%b exp=1", b_valid);
    end
    b_ready = 1;
    tick();
    b_ready = 0;
    checks++;
    if (b_valid !== 1'b0 || err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL wr_done b_valid=%b err_cnt=%0d exp 0/1", b_valid, err_cnt);
    end
  endtask

  task automatic test_long_read();
    int beats = 0;
    int bad = 0;
    int cyc = 0;
    logic hs;
    ar_valid = 1; ar_addr = 32'h3000_0000; ar_id = 4'd9; ar_len = 8'd255;
    #1;
    checks++;
    if (ar_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd_ar_ready got=%b exp=1", ar_ready);
    end
    tick();
    ar_valid = 0;
    while (beats < 256 && cyc < 1200) begin
      r_ready = cyc[0];
      #1;
      // every cycle before the final handshake must present a fully specified beat
      if (r_valid !== 1'b1 || r_data !== 32'h0 || r_resp !== 2'b11 || r_id !== 4'd9 ||
          r_last !== (beats == 255))
        bad++;
      hs = r_valid && r_ready;
      tick();
      if (hs) beats++;
      cyc++;
    end
    r_ready = 0;
    checks++;
    if (beats !== 256) begin
      failures++;
      $display("FAIL rd_beats got=%0d exp=256", beats);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rd_beat_fields bad_cycles=%0d exp=0", bad);
    end
    checks++;
    if (r_valid !== 1'b0 || r_last !== 1'b0 || err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL rd_done r_valid=%b r_last=%b err_cnt=%0d exp 0/0/2", r_valid, r_last, err_cnt);
    end
  endtask

  task automatic test_overlap();
    start_addr = {32'h1A10_0000, 32'h0000_0000, 32'h0000_0000};
    end_addr   = {32'h1A11_FFFF, 32'h0000_00FF, 32'h0000_00FF};
    aw_addr = 32'h10;
    #1;
    checks++;
    if (aw_sel !== 3'b001 || aw_miss !== 1'b0) begin
      failures++;
      $display("FAIL overlap_low sel=%b miss=%b exp 001/0", aw_sel, aw_miss);
    end
    region_en = 3'b110;
    #1;
    checks++;
    if (aw_sel !== 3'b010) begin
      failures++;
      $display("FAIL overlap_en sel=%b exp 010", aw_sel);
    end
    set_map();
    aw_addr = 32'h0;
    tick();
  endtask

  task automatic read_miss_len0();
    ar_valid = 1; ar_addr = 32'h4000_0000; ar_len = 8'd0;
    tick();
    ar_valid = 0; r_ready = 1;
    tick();
    r_ready = 0;
  endtask

  task automatic both_miss(input logic clr);
    aw_valid = 1; aw_addr = 32'h3000_0000;
    ar_valid = 1; ar_addr = 32'h4000_0000; ar_len = 8'd0;
    err_clr = clr;
    #1;
    checks++;
    if (aw_ready !== 1'b1 || ar_ready !== 1'b1) begin
      failures++;
      $display("FAIL both_ready aw=%b ar=%b exp 1/1", aw_ready, ar_ready);
    end
    tick();
    aw_valid = 0; ar_valid = 0; err_clr = 0;
  endtask

  task automatic finish_both();
    w_valid = 1; w_last = 1; r_ready = 1; b_ready = 1;
    tick();
    w_valid = 0; w_last = 0; r_ready = 0;
    tick();
    b_ready = 0;
  endtask

  task automatic test_err_sat();
    err_clr = 1;
    tick();
    err_clr = 0;
    checks++;
    if (err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL cnt_clr got=%h exp=00", err_cnt);
    end
    for (int n = 0; n < 254; n++) read_miss_len0();
    checks++;
    if (err_cnt !== 8'hFE) begin
      failures++;
      $display("FAIL cnt_fill got=%h exp=fe", err_cnt);
    end
    both_miss(1'b0);
    checks++;
    if (err_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL cnt_sat got=%h exp=ff", err_cnt);
    end
    finish_both();
    read_miss_len0();
    checks++;
    if (err_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL cnt_hold got=%h exp=ff", err_cnt);
    end
    both_miss(1'b1);
    checks++;
    if (err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL cnt_clr_prio got=%h exp=00", err_cnt);
    end
    finish_both();
  endtask

  task automatic test_reset_mid_burst();
    ar_valid = 1; ar_addr = 32'h3000_0000; ar_id = 4'd6; ar_len = 8'd7;
    tick();
    ar_valid = 0; r_ready = 1;
    tick();
    tick();
    r_ready = 0;
    checks++;
    if (r_valid !== 1'b1 || r_last !== 1'b0 || r_id !== 4'd6) begin
      failures++;
      $display("FAIL mid_beat3 valid=%b last=%b id=%0d exp 1/0/6", r_valid, r_last, r_id);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (r_valid !== 1'b0 || r_last !== 1'b0 || r_resp !== 2'b00 || r_id !== 4'd0 ||
        err_cnt !== 8'h00 || b_valid !== 1'b0 || w_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset valid=%b last=%b resp=%b id=%0d cnt=%h exp all zero",
               r_valid, r_last, r_resp, r_id, err_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    ar_valid = 1; ar_addr = 32'h1A12_0000; ar_id = 4'd3; ar_len = 8'd1;
    #1;
    checks++;
    if (ar_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_ar_ready got=%b exp=1", ar_ready);
    end
    tick();
    ar_valid = 0;
    checks++;
    if (r_valid !== 1'b1 || r_id !== 4'd3 || r_last !== 1'b0) begin
      failures++;
      $display("FAIL post_beat1 valid=%b id=%0d last=%b exp 1/3/0", r_valid, r_id, r_last);
    end
    r_ready = 1;
    tick();
    checks++;
    if (r_valid !== 1'b1 || r_last !== 1'b1) begin
      failures++;
      $display("FAIL post_beat2 valid=%b last=%b exp 1/1", r_valid, r_last);
    end
    tick();
    r_ready = 0;
    checks++;
    if (r_valid !== 1'b0 || err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL post_done valid=%b cnt=%0d exp 0/1", r_valid, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_write();
    test_long_read();
    test_overlap();
    test_err_sat();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
